cond_exec_unit: RTL and testbench
=================================

// Module: cond_exec_unit
// PURPOSE
//  Execute-stage conditional-execution unit. Sits between the ID/EX register
//  outputs and the EX/MEM register inputs.
//  Holds the NZCV flags register and evaluates the 4-bit condition field
//  against it. Gates PCSrc/RegWrite/MemWrite/Branch before they enter EX/MEM.
//  Squashes the wrong-path instructions that follow a taken branch, or a write
//  to R15, until the redirected PC reaches execute.
// PARAMETERS
//  KILL_SLOTS  4  execute-stage slots squashed after a taken branch or PC write (1..15)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  start        in   1  pipeline run enable; 0 = freeze unit state
//  ALUFlagsE    in   4  ALU flags from execute, {N,Z,C,V}
//  CondE        in   4  condition field of the instruction in execute
//  FlagWriteE   in   2  [1] = update N,Z; [0] = update C,V
//  PCSrcE       in   1  instruction writes R15 (RegWrite with Rd=15)
//  BranchE      in   1  B instruction in execute
//  RegWriteE    in   1  register write request
//  MemWriteE    in   1  memory write request
//  PCSrcEX      out  1  gated redirect (PCSrcE|BranchE), to EX/MEM
//  RegWriteEX   out  1  gated register write, to EX/MEM
//  MemWriteEX   out  1  gated memory write, to EX/MEM
//  CondExE      out  1  condition passed (ungated by kill)
//  KillE        out  1  instruction in execute is being squashed
//  FlagsQ       out  4  current flags register {N,Z,C,V}
// BEHAVIOUR
//  - Reset (reset=0, async): FlagsQ=4'b0000, kill counter=0.
//    Therefore KillE=0, and all gated outputs are 0 while reset is asserted.
//  - CondExE is combinational from CondE and the registered FlagsQ, never the
//    same-cycle ALUFlagsE. Condition table:
//    EQ Z | NE !Z | CS C | CC !C | MI N | PL !N | VS V | VC !V
//    HI C&!Z | LS !C|Z | GE N==V | LT N!=V | GT !Z&(N==V) | LE Z|(N!=V)
//    AL(1110)=1 | 1111=0
//  - Live = CondExE & ~KillE & start.
//    PCSrcEX=(PCSrcE|BranchE)&Live, RegWriteEX=RegWriteE&Live,
//    MemWriteEX=MemWriteE&Live. All combinational, zero latency.
//  - Flags update at the clock edge only when Live:
//    FlagWriteE[1] loads N,Z from ALUFlagsE; FlagWriteE[0] loads C,V.
//    Each half updates independently.
//  - Kill counter width is $clog2(KILL_SLOTS+1). At the edge:
//    if !start, hold; else if PCSrcEX, load KILL_SLOTS;
//    else if cnt!=0, decrement. KillE = (cnt!=0).
//  - A redirect cannot occur while KillE=1, because it is gated by Live.
//    The counter is therefore never reloaded mid-squash.
//  - start=0: flags and counter hold; all gated outputs are 0.
//    CondExE remains valid.
//  - A squashed instruction never writes flags.
//  - Reset asserted mid-squash clears the counter immediately (async).
//  - Simultaneous taken branch and FlagWrite in the same instruction:
//    both take effect at the same edge.
// STRUCTURE
//  - Shared package cond_pkg:
//    - cond_t enum of 16 codes (EQ..AL, NV=4'hF).
//    - Flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
//    - FLAGWR_NZ and FLAGWR_CV bit positions.
//  - Sub-module cond_check (combinational): cond_t + 4-bit flags -> CondExE.
//    Reused later by the hazard/forwarding work.
//  - Flags register and kill counter live in this top module.
// TESTING
//  1. Reset low mid-run with cnt=3 -> FlagsQ=0, KillE=0 and all gated
//     outputs 0 immediately, before any clock edge.
//  2. CondE=AL, FlagWriteE=2'b11, ALUFlagsE=4'b0110
//     -> FlagsQ=4'b0110 next cycle. Then CondE=EQ, RegWriteE=1
//     -> RegWriteEX=1. Then CondE=NE -> RegWriteEX=0.
//  3. FlagsQ=4'b1001, sweep all 16 CondE values
//     -> CondExE matches the table (GE=1, LT=0, HI=0, LS=1, NV=0).
//  4. CondE=AL, BranchE=1 -> PCSrcEX=1, then KillE=1 for exactly 4 cycles.
//     During the squash, MemWriteE=1 and BranchE=1 give MemWriteEX=0 and
//     PCSrcEX=0. The 5th cycle passes normally.
//  5. Taken branch with FlagWriteE=2'b10, ALUFlagsE=4'b1000
//     -> N updates, C/V hold.
//     Then a squashed slot with FlagWriteE=2'b11 -> FlagsQ unchanged.
//  6. start=0 for 3 cycles in the middle of a squash (cnt=2)
//     -> cnt holds at 2 and gated outputs are 0.
//     After start=1, KillE remains for 2 more cycles.

Source files
------------

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes, flag indices and flag-write bit positions
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGWR_NZ = 1;
    localparam int FLAGWR_CV = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational condition-field evaluation against NZCV flags
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_t'(cond_i))
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            COND_NV: cond_ex_o = 1'b0;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_unit.sv
// rtl/cond_exec_unit.sv - execute-stage flags register, condition gating and wrong-path squash
module cond_exec_unit
    import cond_pkg::*;
#(
    parameter int KILL_SLOTS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] ALUFlagsE,
    input  logic [3:0] CondE,
    input  logic [1:0] FlagWriteE,
    input  logic       PCSrcE,
    input  logic       BranchE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    output logic       PCSrcEX,
    output logic       RegWriteEX,
    output logic       MemWriteEX,
    output logic       CondExE,
    output logic       KillE,
    output logic [3:0] FlagsQ
);

    localparam int CNT_W = $clog2(KILL_SLOTS + 1);
    localparam logic [CNT_W-1:0] KILL_LOAD = CNT_W'(KILL_SLOTS);

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
    logic             live;

    cond_check u_cond_check (
        .cond_i    (CondE),
        .flags_i   (flags_q),
        .cond_ex_o (CondExE)
    );

    // reset is folded in so nothing leaks into EX/MEM while the unit is held in reset
    assign KillE      = (kill_cnt_q != '0);
    assign live       = CondExE & ~KillE & start & reset;
    assign PCSrcEX    = (PCSrcE | BranchE) & live;
    assign RegWriteEX = RegWriteE & live;
    assign MemWriteEX = MemWriteE & live;
    assign FlagsQ     = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (live && FlagWriteE[FLAGWR_NZ]) begin
            flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
            flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
        end
        if (live && FlagWriteE[FLAGWR_CV]) begin
            flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
            flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
        end
    end

    // a redirect is gated by live, so the counter is never reloaded mid-squash
    always_comb begin
        kill_cnt_d = kill_cnt_q;
        if (start) begin
            if (PCSrcEX)
                kill_cnt_d = KILL_LOAD;
            else if (kill_cnt_q != '0)
                kill_cnt_d = kill_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q    <= 4'b0000;
            kill_cnt_q <= '0;
        end else begin
            flags_q    <= flags_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// tb/tb_cond_exec_unit.sv - directed self-checking bench for cond_exec_unit
module tb_cond_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] ALUFlagsE;
    logic [3:0] CondE;
    logic [1:0] FlagWriteE;
    logic       PCSrcE;
    logic       BranchE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       PCSrcEX;
    logic       RegWriteEX;
    logic       MemWriteEX;
    logic       CondExE;
    logic       KillE;
    logic [3:0] FlagsQ;

    int tests  = 0;
    int failed = 0;
    logic [15:0] sweep_exp;

    cond_exec_unit #(.KILL_SLOTS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUFlagsE  (ALUFlagsE),
        .CondE      (CondE),
        .FlagWriteE (FlagWriteE),
        .PCSrcE     (PCSrcE),
        .BranchE    (BranchE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .PCSrcEX    (PCSrcEX),
        .RegWriteEX (RegWriteEX),
        .MemWriteEX (MemWriteEX),
        .CondExE    (CondExE),
        .KillE      (KillE),
        .FlagsQ     (FlagsQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gated(input string tag, input logic pc, input logic rw, input logic mw);
        chk({tag, "_pcsrc"}, {31'd0, PCSrcEX}, {31'd0, pc});
        chk({tag, "_regwr"}, {31'd0, RegWriteEX}, {31'd0, rw});
        chk({tag, "_memwr"}, {31'd0, MemWriteEX}, {31'd0, mw});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ALUFlagsE = 4'h0; CondE = 4'hE; FlagWriteE = 2'b00;
        PCSrcE = 1'b0; BranchE = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b1;
        #2;
        chk("rst_flags", {28'd0, FlagsQ}, 32'h0);
        chk("rst_kill", {31'd0, KillE}, 32'h0);
        chk_gated("rst", 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        reset = 1'b1; start = 1'b1; RegWriteE = 1'b0; MemWriteE = 1'b0;
        tick();

        // flag load then EQ / NE gating
        CondE = 4'hE; FlagWriteE = 2'b11; ALUFlagsE = 4'b0110;
        tick();
        chk("t2_flags", {28'd0, FlagsQ}, 32'h6);
        CondE = 4'h0; FlagWriteE = 2'b00; RegWriteE = 1'b1;
        #1 chk("t2_eq_regwr", {31'd0, RegWriteEX}, 32'h1);
        CondE = 4'h1;
        #1 chk("t2_ne_regwr", {31'd0, RegWriteEX}, 32'h0);
        RegWriteE = 1'b0;

        // condition sweep with N=1 Z=0 C=0 V=1
        tick();
        CondE = 4'hE; FlagWriteE = 2'b11; ALUFlagsE = 4'b1001;
        tick();
        FlagWriteE = 2'b00;
        chk("t3_flags", {28'd0, FlagsQ}, 32'h9);
        sweep_exp = 16'h565A;
        for (int i = 0; i < 16; i++) begin
            CondE = 4'(i);
            #1 chk($sformatf("t3_cond_%0d", i), {31'd0, CondExE}, {31'd0, sweep_exp[i]});
        end

        // taken branch squashes exactly four slots
        tick();
        CondE = 4'hE; BranchE = 1'b1;
        #1 chk("t4_pcsrc", {31'd0, PCSrcEX}, 32'h1);
        tick();
        MemWriteE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_kill_%0d", i), {31'd0, KillE}, 32'h1);
            chk_gated($sformatf("t4_sq_%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        BranchE = 1'b0;
        #1;
        chk("t4_after_kill", {31'd0, KillE}, 32'h0);
        chk("t4_after_memwr", {31'd0, MemWriteEX}, 32'h1);
        MemWriteE = 1'b0;

        // partial flag write on a taken branch, then a squashed flag write
        tick();
        CondE = 4'hE; FlagWriteE = 2'b11; ALUFlagsE = 4'b0011;
        tick();
        chk("t5_pre_flags", {28'd0, FlagsQ}, 32'h3);
        BranchE = 1'b1; FlagWriteE = 2'b10; ALUFlagsE = 4'b1000;
        tick();
        chk("t5_nz_only", {28'd0, FlagsQ}, 32'hB);
        chk("t5_kill", {31'd0, KillE}, 32'h1);
        BranchE = 1'b0; FlagWriteE = 2'b11; ALUFlagsE = 4'b0100;
        tick();
        chk("t5_squash_flags", {28'd0, FlagsQ}, 32'hB);
        FlagWriteE = 2'b00;
        tick();

        // freeze with two squash slots left
        start = 1'b0; BranchE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t6_hold_kill_%0d", i), {31'd0, KillE}, 32'h1);
            chk($sformatf("t6_hold_cond_%0d", i), {31'd0, CondExE}, 32'h1);
            chk_gated($sformatf("t6_hold_%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_resume_kill_%0d", i), {31'd0, KillE}, 32'h1);
            chk_gated($sformatf("t6_resume_%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        BranchE = 1'b0;
        #1;
        chk("t6_done_kill", {31'd0, KillE}, 32'h0);
        chk_gated("t6_done", 1'b0, 1'b1, 1'b1);

        // async reset mid-squash with three slots left
        RegWriteE = 1'b0; MemWriteE = 1'b0; BranchE = 1'b1;
        tick();
        BranchE = 1'b0;
        tick();
        chk("t1_mid_kill", {31'd0, KillE}, 32'h1);
        BranchE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("t1_async_flags", {28'd0, FlagsQ}, 32'h0);
        chk("t1_async_kill", {31'd0, KillE}, 32'h0);
        chk_gated("t1_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
